// File: rtl/haze_ctrl_pkg.sv
// Shared types for the haze frame controller: FSM states, the dehaze
// parameter set and its power-on default.
package haze_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        ARMED,
        ACTIVE
    } ctrl_state_t;

    typedef struct packed {
        logic [7:0] air;
        logic [7:0] omega;
        logic [7:0] t0;
    } dehaze_cfg_t;

    function automatic dehaze_cfg_t make_cfg(input logic [7:0] air,
                                             input logic [7:0] omega,
                                             input logic [7:0] t0);
        dehaze_cfg_t c;
        c.air   = air;
        c.omega = omega;
        c.t0    = t0;
        return c;
    endfunction

    // Atmospheric light 255, omega ~0.95, t0 ~0.1 (Q0.8)
    localparam dehaze_cfg_t DEF_CFG = '{air: 8'd255, omega: 8'd243, t0: 8'd26};

endpackage

// File: rtl/haze_geom_check.sv
// Per-frame geometry checker: counts pixels per line and lines per frame
// while a frame is admitted, and pulses mismatch_o on any deviation.
module haze_geom_check #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active_i,
    input  logic frame_end_i,
    input  logic href_i,
    input  logic clken_i,
    output logic mismatch_o
);

    // Widths leave headroom so the saturated value never equals the target
    localparam int unsigned PW = $clog2(IMG_HDISP + 2);
    localparam int unsigned LW = $clog2(IMG_VDISP + 2);
    localparam logic [PW-1:0] HD = PW'(IMG_HDISP);
    localparam logic [LW-1:0] VD = LW'(IMG_VDISP);

    logic          href_prev_q;
    logic [PW-1:0] pix_q, pix_d;
    logic [LW-1:0] line_q, line_d, line_now;
    logic          href_fall;

    assign href_fall = href_prev_q & ~href_i;

    // Counter next-state and mismatch detection; a line closing on the frame-end
    // cycle is included in the line total
    always_comb begin
        pix_d      = pix_q;
        line_d     = line_q;
        line_now   = line_q;
        mismatch_o = 1'b0;
        if (active_i) begin
            if (href_fall) begin
                if (pix_q != HD) mismatch_o = 1'b1;
                pix_d = '0;
                if (line_q != '1) line_now = line_q + LW'(1);
            end else if (href_i && clken_i && (pix_q != '1)) begin
                pix_d = pix_q + PW'(1);
            end
            line_d = line_now;
            if (frame_end_i) begin
                if (line_now != VD) mismatch_o = 1'b1;
                pix_d  = '0;
                line_d = '0;
            end
        end else begin
            pix_d  = '0;
            line_d = '0;
        end
    end

    // Counter and href edge-detect registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            href_prev_q <= 1'b0;
            pix_q       <= '0;
            line_q      <= '0;
        end else begin
            href_prev_q <= href_i;
            pix_q       <= pix_d;
            line_q      <= line_d;
        end
    end

endmodule

// File: rtl/haze_frame_ctrl.sv
// Frame-level admission gate, parameter double-buffer and geometry status
// in front of the haze-removal pipeline.
module haze_frame_ctrl import haze_ctrl_pkg::*; #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int DEF_AIR   = 255,
    parameter int DEF_OMEGA = 243,
    parameter int DEF_T0    = 26,
    parameter int FCNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              pre_frame_vsync,
    input  logic              pre_frame_href,
    input  logic              pre_frame_clken,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [7:0]        cfg_air,
    input  logic [7:0]        cfg_omega,
    input  logic [7:0]        cfg_t0,
    output logic [7:0]        act_air,
    output logic [7:0]        act_omega,
    output logic [7:0]        act_t0,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              geom_err,
    input  logic              err_clr,
    output logic              busy
);

    localparam dehaze_cfg_t RST_CFG = make_cfg(8'(DEF_AIR), 8'(DEF_OMEGA), 8'(DEF_T0));

    ctrl_state_t       state_q, state_d;
    logic              vsync_prev_q;
    logic              vs_rise, vs_fall, frame_start, frame_end, gate;
    dehaze_cfg_t       act_q, act_d, pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              gerr_q, gerr_d;
    logic              post_vs_q, post_hr_q, post_ck_q;
    logic              mismatch;

    assign vs_rise = pre_frame_vsync & ~vsync_prev_q;
    assign vs_fall = ~pre_frame_vsync & vsync_prev_q;

    // Admission FSM: only a vsync rise seen after vsync was low opens the gate
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            IDLE:   if (enable) state_d = SYNC;
            SYNC: begin
                if (!enable)               state_d = IDLE;
                else if (!pre_frame_vsync) state_d = ARMED;
            end
            ARMED: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (vs_rise) begin
                    state_d     = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_fall) begin
                    frame_end = 1'b1;
                    state_d   = enable ? ARMED : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        gate = (state_q == ACTIVE) | frame_start;
    end

    // State and vsync edge-detect registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            vsync_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_prev_q <= pre_frame_vsync;
        end
    end

    // Parameter double-buffer: the pending slot is promoted only at frame start,
    // so a set accepted in the frame-start cycle waits for the next frame
    always_comb begin
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (frame_start && pend_full_q) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
        end else if (cfg_valid && !pend_full_q) begin
            pend_d      = make_cfg(cfg_air, cfg_omega, cfg_t0);
            pend_full_d = 1'b1;
        end
    end

    // Active and pending parameter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q       <= RST_CFG;
            pend_q      <= RST_CFG;
            pend_full_q <= 1'b0;
        end else begin
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
        end
    end

    haze_geom_check #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP)
    ) u_geom (
        .clk_i       (clk),
        .rst_i       (rst),
        .active_i    (state_q == ACTIVE),
        .frame_end_i (frame_end),
        .href_i      (pre_frame_href),
        .clken_i     (pre_frame_clken),
        .mismatch_o  (mismatch)
    );

    // Frame counter and sticky error next-state; a new mismatch beats a clear
    always_comb begin
        fcnt_d = fcnt_q + FCNT_W'(frame_end);
        gerr_d = gerr_q;
        if (mismatch)     gerr_d = 1'b1;
        else if (err_clr) gerr_d = 1'b0;
    end

    // Status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q <= '0;
            gerr_q <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            gerr_q <= gerr_d;
        end
    end

    // Gated timing to the pipeline, one cycle of latency on every sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_vs_q <= 1'b0;
            post_hr_q <= 1'b0;
            post_ck_q <= 1'b0;
        end else begin
            post_vs_q <= pre_frame_vsync & gate;
            post_hr_q <= pre_frame_href  & gate;
            post_ck_q <= pre_frame_clken & gate;
        end
    end

    assign post_frame_vsync = post_vs_q;
    assign post_frame_href  = post_hr_q;
    assign post_frame_clken = post_ck_q;
    assign cfg_ready        = ~pend_full_q;
    assign act_air          = act_q.air;
    assign act_omega        = act_q.omega;
    assign act_t0           = act_q.t0;
    assign frame_cnt        = fcnt_q;
    assign geom_err         = gerr_q;
    assign busy             = (state_q == ACTIVE);

endmodule

// File: tb/tb_haze_frame_ctrl.sv
// Directed bench for haze_frame_ctrl on a scaled-down 8x6 frame geometry.
module tb_haze_frame_ctrl;
    import haze_ctrl_pkg::*;

    localparam int HD = 8;
    localparam int VD = 6;
    localparam int HB = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, pvs, phr, pck, cfg_valid, err_clr;
    logic [7:0]  cair, com, ct0;

    logic        o_vs, o_hr, o_ck, cfg_ready, geom_err, busy;
    logic [7:0]  act_air, act_omega, act_t0;
    logic [15:0] frame_cnt;

    logic        o_vs2, o_hr2, o_ck2, cfg_ready2, geom_err2, busy2;
    logic [7:0]  act_air2, act_omega2, act_t02;
    logic [1:0]  frame_cnt2;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int exp_fc   = 0;
    int base;

    always #5 clk = ~clk;

    haze_frame_ctrl #(
        .IMG_HDISP (HD),
        .IMG_VDISP (VD)
    ) dut (
        .clk (clk), .rst (rst), .enable (enable),
        .pre_frame_vsync (pvs), .pre_frame_href (phr), .pre_frame_clken (pck),
        .post_frame_vsync (o_vs), .post_frame_href (o_hr), .post_frame_clken (o_ck),
        .cfg_valid (cfg_valid), .cfg_ready (cfg_ready),
        .cfg_air (cair), .cfg_omega (com), .cfg_t0 (ct0),
        .act_air (act_air), .act_omega (act_omega), .act_t0 (act_t0),
        .frame_cnt (frame_cnt), .geom_err (geom_err), .err_clr (err_clr), .busy (busy)
    );

    haze_frame_ctrl #(
        .IMG_HDISP (HD),
        .IMG_VDISP (VD),
        .FCNT_W    (2)
    ) dut2 (
        .clk (clk), .rst (rst), .enable (enable),
        .pre_frame_vsync (pvs), .pre_frame_href (phr), .pre_frame_clken (pck),
        .post_frame_vsync (o_vs2), .post_frame_href (o_hr2), .post_frame_clken (o_ck2),
        .cfg_valid (cfg_valid), .cfg_ready (cfg_ready2),
        .cfg_air (cair), .cfg_omega (com), .cfg_t0 (ct0),
        .act_air (act_air2), .act_omega (act_omega2), .act_t0 (act_t02),
        .frame_cnt (frame_cnt2), .geom_err (geom_err2), .err_clr (err_clr), .busy (busy2)
    );

    always @(negedge clk) if (o_ck) pulses++;

    typedef struct {
        logic en, vs, hr, ck, ec;
        logic pvs, phr, pck, bsy;
        int   fc;
        logic ge;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t vec(input logic en, vs, hr, ck, ec,
                                 input logic e_vs, e_hr, e_ck, e_bsy,
                                 input int e_fc, input logic e_ge);
        vec_t v;
        v.en = en; v.vs = vs; v.hr = hr; v.ck = ck; v.ec = ec;
        v.pvs = e_vs; v.phr = e_hr; v.pck = e_ck; v.bsy = e_bsy;
        v.fc = e_fc; v.ge = e_ge;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        pvs = 1'b0; phr = 1'b0; pck = 1'b0;
        repeat (n) step();
    endtask

    task automatic rise();
        pvs = 1'b1; phr = 1'b0; pck = 1'b0;
        step();
    endtask

    task automatic lines(input int from, input int to, input int short_line);
        for (int l = from; l <= to; l++) begin
            phr = 1'b1; pck = 1'b1;
            repeat ((l == short_line) ? HD - 1 : HD) step();
            phr = 1'b0; pck = 1'b0;
            repeat (HB) step();
        end
    endtask

    task automatic fall();
        pvs = 1'b0; phr = 1'b0; pck = 1'b0;
        step();
    endtask

    task automatic full_frame(input int short_line, input int exp_admit, input string tag);
        gap(3);
        rise();
        chk({tag, "_vs_rise"}, int'(o_vs), exp_admit);
        step();
        lines(0, VD - 1, short_line);
        fall();
        chk({tag, "_vs_fall"}, int'(o_vs), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp2 [5];
        exp2 = '{1, 2, 3, 0, 1};

        //            en vs hr ck ec   pvs phr pck bsy fc ge
        tbl[0]  = vec(0, 1, 1, 1, 0,   0, 0, 0, 0,  0, 0);
        tbl[1]  = vec(1, 1, 1, 1, 0,   0, 0, 0, 0,  0, 0);
        tbl[2]  = vec(1, 1, 0, 0, 0,   0, 0, 0, 0,  0, 0);
        tbl[3]  = vec(0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0);
        tbl[4]  = vec(1, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0);
        tbl[5]  = vec(1, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0);
        tbl[6]  = vec(0, 1, 0, 0, 0,   0, 0, 0, 0,  0, 0);
        tbl[7]  = vec(1, 1, 0, 0, 0,   0, 0, 0, 0,  0, 0);
        tbl[8]  = vec(1, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0);
        tbl[9]  = vec(1, 1, 0, 0, 0,   1, 0, 0, 1,  0, 0);
        tbl[10] = vec(1, 1, 1, 1, 0,   1, 1, 1, 1,  0, 0);
        tbl[11] = vec(1, 1, 1, 0, 0,   1, 1, 0, 1,  0, 0);
        tbl[12] = vec(1, 1, 1, 1, 0,   1, 1, 1, 1,  0, 0);
        tbl[13] = vec(1, 1, 0, 0, 0,   1, 0, 0, 1,  0, 1);
        tbl[14] = vec(1, 0, 0, 0, 1,   0, 0, 0, 0,  1, 1);
        tbl[15] = vec(1, 0, 0, 0, 1,   0, 0, 0, 0,  1, 0);
        tbl[16] = vec(0, 1, 1, 1, 0,   0, 0, 0, 0,  1, 0);
        tbl[17] = vec(0, 1, 1, 1, 0,   0, 0, 0, 0,  1, 0);

        // Reset asserted while the source is mid-frame
        rst = 1'b1; enable = 1'b0; pvs = 1'b1; phr = 1'b1; pck = 1'b1;
        cfg_valid = 1'b0; err_clr = 1'b0; cair = '0; com = '0; ct0 = '0;
        repeat (2) step();
        chk("rst_post", int'({o_vs, o_hr, o_ck}), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_act", int'({act_air, act_omega, act_t0}), int'({8'd255, 8'd243, 8'd26}));
        chk("rst_fcnt", int'(frame_cnt), 0);
        chk("rst_gerr", int'(geom_err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst2_all", int'({o_vs2, o_hr2, o_ck2, geom_err2, busy2, frame_cnt2}), 0);
        chk("rst2_cfg", int'({cfg_ready2, act_air2, act_omega2, act_t02}),
            int'({1'b1, 8'd255, 8'd243, 8'd26}));
        rst = 1'b0;

        // Cycle-level FSM / gating / geometry vectors
        for (int i = 0; i < 18; i++) begin
            enable = tbl[i].en; pvs = tbl[i].vs; phr = tbl[i].hr;
            pck = tbl[i].ck; err_clr = tbl[i].ec;
            step();
            chk($sformatf("vec%0d_vs", i), int'(o_vs), int'(tbl[i].pvs));
            chk($sformatf("vec%0d_hr", i), int'(o_hr), int'(tbl[i].phr));
            chk($sformatf("vec%0d_ck", i), int'(o_ck), int'(tbl[i].pck));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].bsy));
            chk($sformatf("vec%0d_fcnt", i), int'(frame_cnt), tbl[i].fc);
            chk($sformatf("vec%0d_gerr", i), int'(geom_err), int'(tbl[i].ge));
        end
        err_clr = 1'b0;

        // Reset in the middle of an admitted frame
        enable = 1'b1;
        gap(3);
        rise();
        chk("s1_rise", int'(o_vs), 1);
        lines(0, 0, -1);
        phr = 1'b1; pck = 1'b1;
        repeat (3) step();
        chk("s1_href_open", int'({o_hr, o_ck}), 3);
        #2 rst = 1'b1;
        #1 chk("s1_async_post", int'({o_vs, o_hr, o_ck}), 0);
        step();
        rst = 1'b0;
        base = pulses;
        repeat (4) step();
        phr = 1'b0; pck = 1'b0;
        repeat (HB) step();
        lines(2, VD - 1, -1);
        chk("s1_partial_pulses", pulses - base, 0);
        chk("s1_partial_fcnt", int'(frame_cnt), 0);
        base = pulses;
        full_frame(-1, 1, "s1_full");
        chk("s1_pulses", pulses - base, HD * VD);
        chk("s1_fcnt", int'(frame_cnt), 1);
        chk("s1_gerr", int'(geom_err), 0);
        exp_fc = 1;

        // Parameter set offered mid-frame
        gap(3);
        rise();
        step();
        lines(0, 1, -1);
        cfg_valid = 1'b1; cair = 8'd200; com = 8'd230; ct0 = 8'd20;
        step();
        cfg_valid = 1'b0;
        chk("s2_ready_drop", int'(cfg_ready), 0);
        chk("s2_act_hold", int'({act_air, act_omega, act_t0}), int'({8'd255, 8'd243, 8'd26}));
        lines(2, VD - 1, -1);
        fall();
        exp_fc++;
        chk("s2_fcnt", int'(frame_cnt), exp_fc);
        gap(3);
        chk("s2_act_pre_rise", int'({act_air, act_omega, act_t0}), int'({8'd255, 8'd243, 8'd26}));
        rise();
        chk("s2_vs_rise", int'(o_vs), 1);
        chk("s2_act_new", int'({act_air, act_omega, act_t0}), int'({8'd200, 8'd230, 8'd20}));
        chk("s2_ready_back", int'(cfg_ready), 1);
        step();
        lines(0, VD - 1, -1);
        fall();
        exp_fc++;

        // Transfer in the exact frame-start cycle with the slot empty
        gap(3);
        cfg_valid = 1'b1; cair = 8'd10; com = 8'd20; ct0 = 8'd30;
        rise();
        cfg_valid = 1'b0;
        chk("s5_act_same", int'({act_air, act_omega, act_t0}), int'({8'd200, 8'd230, 8'd20}));
        chk("s5_ready", int'(cfg_ready), 0);
        step();
        lines(0, VD - 1, -1);
        fall();
        exp_fc++;
        chk("s5_act_end", int'({act_air, act_omega, act_t0}), int'({8'd200, 8'd230, 8'd20}));
        gap(3);
        rise();
        chk("s5_act_next", int'({act_air, act_omega, act_t0}), int'({8'd10, 8'd20, 8'd30}));
        chk("s5_ready_back", int'(cfg_ready), 1);
        step();
        lines(0, VD - 1, -1);
        fall();
        exp_fc++;
        chk("s5_fcnt", int'(frame_cnt), exp_fc);

        // Enable dropped mid-frame: frame completes, next one is blocked
        gap(3);
        rise();
        base = pulses;
        step();
        lines(0, 2, -1);
        enable = 1'b0;
        lines(3, VD - 1, -1);
        fall();
        exp_fc++;
        chk("s3_pulses", pulses - base, HD * VD);
        chk("s3_fcnt", int'(frame_cnt), exp_fc);
        chk("s3_busy", int'(busy), 0);
        base = pulses;
        full_frame(-1, 0, "s3_blocked");
        chk("s3_blk_pulses", pulses - base, 0);
        chk("s3_blk_fcnt", int'(frame_cnt), exp_fc);
        chk("s3_state", int'(dut.state_q), int'(IDLE));

        // Short line sets the sticky error; clear; clean frame keeps it clear
        enable = 1'b1;
        base = pulses;
        full_frame(2, 1, "s4_short");
        exp_fc++;
        chk("s4_pulses", pulses - base, HD * VD - 1);
        chk("s4_gerr_set", int'(geom_err), 1);
        chk("s4_fcnt", int'(frame_cnt), exp_fc);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("s4_gerr_clr", int'(geom_err), 0);
        base = pulses;
        full_frame(-1, 1, "s4_clean");
        exp_fc++;
        chk("s4_clean_pulses", pulses - base, HD * VD);
        chk("s4_clean_gerr", int'(geom_err), 0);
        chk("s4_clean_fcnt", int'(frame_cnt), exp_fc);

        // Narrow frame counter wraps
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            full_frame(-1, 1, $sformatf("s6_f%0d", k));
            chk($sformatf("s6_fcnt2_%0d", k), int'(frame_cnt2), exp2[k]);
            chk($sformatf("s6_fcnt_%0d", k), int'(frame_cnt), k + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
